// File: rtl/store_align_queue_pkg.sv
// Shared types for the store aligner/queue: access-size encoding, queue entry layout and
// the size-to-strobe helper.
package store_align_queue_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 32;

    // Entry layout at the default bus configuration; the queue builds the same shape from
    // its own parameters.
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]   addr;
        logic [DEF_DATA_WIDTH-1:0]   data;
        logic [DEF_DATA_WIDTH/8-1:0] strb;
    } store_entry_t;

    function automatic logic [7:0] size_mask(msize_t msize);
        logic [7:0] mask;
        unique case (msize)
            MSIZE1:  mask = 8'h01;
            MSIZE2:  mask = 8'h03;
            MSIZE4:  mask = 8'h0f;
            default: mask = 8'hff;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/store_align_queue_if.sv
// Request/bus-side signal bundle of store_align_queue; slave = the queue, master = its driver.
interface store_align_queue_if
    import store_align_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;

    logic                    in_valid;
    logic                    in_ready;
    logic [ADDR_WIDTH-1:0]   in_addr;
    msize_t                  in_msize;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    misalign;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_WIDTH-1:0]   out_addr;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [DATA_BYTES-1:0]   out_strb;
    logic [$clog2(DEPTH):0]  count;
    logic                    empty;

    modport master (
        output in_valid, in_addr, in_msize, in_data, out_ready,
        input  in_ready, misalign, out_valid, out_addr, out_data, out_strb, count, empty
    );

    modport slave (
        input  in_valid, in_addr, in_msize, in_data, out_ready,
        output in_ready, misalign, out_valid, out_addr, out_data, out_strb, count, empty
    );

endinterface

// File: rtl/store_align_queue_lane.sv
// store_lane_align: combinational placement of right-justified store data into byte lanes,
// with strobe generation and misalignment detection.
module store_lane_align
    import store_align_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned DATA_BYTES = DATA_WIDTH / 8,
    localparam int unsigned OFFW       = $clog2(DATA_BYTES)
) (
    input  logic [OFFW-1:0]       off,
    input  msize_t                msize,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] data,
    output logic [DATA_BYTES-1:0] strb,
    output logic                  misalign
);
    logic [3:0]            nbytes;
    logic [DATA_BYTES-1:0] lmask;
    logic [DATA_WIDTH-1:0] bmask;

    always_comb begin
        nbytes = 4'd1 << msize;
        lmask  = DATA_BYTES'(size_mask(msize));
        bmask  = '0;
        for (int i = 0; i < int'(DATA_BYTES); i++) begin
            bmask[8*i +: 8] = {8{lmask[i]}};
        end
        data     = (wdata & bmask) << {off, 3'b000};
        strb     = lmask << off;
        // Wider-than-bus accesses are rejected even when the offset looks aligned.
        misalign = ((off & OFFW'(nbytes - 4'd1)) != '0) || (32'(nbytes) > DATA_BYTES);
    end

endmodule

// File: rtl/store_align_queue.sv
// Store aligner plus DEPTH-entry FIFO toward the data bus.
// Define STORE_MERGE_EN to merge same-word stores into the youngest queued entry.
module store_align_queue
    import store_align_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input logic          clk,
    input logic          reset,
    store_align_queue_if.slave bus
);
    localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFFW       = $clog2(DATA_BYTES);
    localparam int unsigned PW         = $clog2(DEPTH);
    localparam int unsigned CW         = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_BYTES-1:0] strb;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [PW-1:0]         head_ptr_q, head_ptr_d;
    logic [PW-1:0]         tail_ptr_q, tail_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [DATA_WIDTH-1:0] al_data;
    logic [DATA_BYTES-1:0] al_strb;
    logic                  al_misalign;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  accept, pop, push, merge, head_valid;
`ifdef STORE_MERGE_EN
    logic [PW-1:0]         tail_last;
`endif

    store_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .off      (bus.in_addr[OFFW-1:0]),
        .msize    (bus.in_msize),
        .wdata    (bus.in_data),
        .data     (al_data),
        .strb     (al_strb),
        .misalign (al_misalign)
    );

    always_comb begin
        word_addr  = {bus.in_addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
        head_valid = (count_q != '0);
        pop        = head_valid && bus.out_ready;
        merge      = 1'b0;
`ifdef STORE_MERGE_EN
        tail_last = tail_ptr_q - PW'(1);
        // A lone entry that is leaving this cycle cannot absorb new bytes.
        merge = bus.in_valid && !al_misalign && head_valid
             && (mem[tail_last].addr == word_addr)
             && !((count_q == CW'(1)) && pop);
`endif
        bus.in_ready = (count_q < CW'(DEPTH)) || merge;
        accept       = bus.in_valid && bus.in_ready;
        push         = accept && !al_misalign && !merge;
        bus.misalign = accept && al_misalign;

        count_d    = count_q + CW'(push) - CW'(pop);
        head_ptr_d = head_ptr_q + PW'(pop);
        tail_ptr_d = tail_ptr_q + PW'(push);

        bus.count     = count_q;
        bus.empty     = !head_valid;
        bus.out_valid = head_valid;
        bus.out_addr  = head_valid ? mem[head_ptr_q].addr : '0;
        bus.out_data  = head_valid ? mem[head_ptr_q].data : '0;
        bus.out_strb  = head_valid ? mem[head_ptr_q].strb : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
        end else begin
            count_q    <= count_d;
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
        end
    end

    // Storage is not reset; outputs are gated by occupancy instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_ptr_q] <= '{addr: word_addr, data: al_data, strb: al_strb};
        end
`ifdef STORE_MERGE_EN
        if (merge) begin
            for (int i = 0; i < int'(DATA_BYTES); i++) begin
                if (al_strb[i]) begin
                    mem[tail_last].data[8*i +: 8] <= al_data[8*i +: 8];
                end
            end
            mem[tail_last].strb <= mem[tail_last].strb | al_strb;
        end
`endif
    end

endmodule
